// File: rtl/alu_datapath_seq.sv
// alu_datapath_seq
//   Register file + ALU with flag register + byte-serial memory sequencer,
//   driven by a valid/ready command interface.
//
// Ports:
//   Clock, Reset                   rising-edge clock, async active-low reset
//   Cmd_Valid / Cmd_Ready          command handshake (Ready only in IDLE)
//   Cmd_Op, Cmd_WF, Cmd_Dst,
//   Cmd_SrcA, Cmd_SrcB, Cmd_Imm,
//   Cmd_Addr                       command fields, latched at acceptance
//   Done                           one-cycle completion pulse
//   Result                         value written/stored by the last command
//   FlagsOut                       {Z,C,N,O}
//   Mem_CS, Mem_WR, Mem_Address,
//   Mem_WData, Mem_RData           byte-wide memory port (outputs registered)
//   Dbg_Sel / Dbg_Data             combinational register observation
module alu_datapath_seq #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = 16,
  localparam int unsigned BYTES   = DATA_W / 8,
  localparam int unsigned RSEL_W  = $clog2(NUM_REGS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic [2:0]        Cmd_Op,
  input  logic              Cmd_WF,
  input  logic [RSEL_W-1:0] Cmd_Dst,
  input  logic [RSEL_W-1:0] Cmd_SrcA,
  input  logic [RSEL_W-1:0] Cmd_SrcB,
  input  logic [DATA_W-1:0] Cmd_Imm,
  input  logic [ADDR_W-1:0] Cmd_Addr,
  output logic              Done,
  output logic [DATA_W-1:0] Result,
  output logic [3:0]        FlagsOut,
  output logic              Mem_CS,
  output logic              Mem_WR,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [7:0]        Mem_WData,
  input  logic [7:0]        Mem_RData,
  input  logic [RSEL_W-1:0] Dbg_Sel,
  output logic [DATA_W-1:0] Dbg_Data
);

  localparam int unsigned KW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned MSB = DATA_W - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MEM_RD, S_MEM_WR, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_LOADI = 3'b101,
    OP_LOAD  = 3'b110,
    OP_STORE = 3'b111
  } op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                wf_q, wf_d;
  logic [RSEL_W-1:0]   dst_q, dst_d;
  logic [RSEL_W-1:0]   srca_q, srca_d;
  logic [RSEL_W-1:0]   srcb_q, srcb_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   snap_q, snap_d;
  logic [DATA_W-1:0]   ld_q, ld_d;
  logic [KW-1:0]       k_q, k_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          flags_q, flags_d;
  logic                cs_q, cs_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [7:0]          wdata_q, wdata_d;

  logic [DATA_W-1:0]   opa, opb, alu_res, ld_word, exec_res;
  logic [DATA_W:0]     ext;
  logic                alu_c, alu_o;
  logic [3:0]          alu_flags;
  logic                last_k;

  // ALU on the latched operand selects; valid during EXEC.
  always_comb begin
    opa     = regs_q[srca_q];
    opb     = regs_q[srcb_q];
    ext     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (op_q)
      OP_ADD: begin
        ext     = {1'b0, opa} + {1'b0, opb};
        alu_res = ext[DATA_W-1:0];
        alu_c   = ext[DATA_W];
        alu_o   = (opa[MSB] == opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_SUB: begin
        // Bit DATA_W of the extended difference is the borrow.
        ext     = {1'b0, opa} - {1'b0, opb};
        alu_res = ext[DATA_W-1:0];
        alu_c   = ext[DATA_W];
        alu_o   = (opa[MSB] != opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      default: alu_res = '0;
    endcase
    alu_flags = {(alu_res == '0), alu_c, alu_res[MSB], alu_o};
  end

  always_comb begin
    last_k = (k_q == KW'(BYTES - 1));
    // Current read byte merged into the partially assembled word.
    ld_word = ld_q;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (k_q == KW'(b)) ld_word[8*b +: 8] = Mem_RData;
    end
    exec_res = (op_q == OP_LOADI) ? imm_q : alu_res;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wf_d     = wf_q;
    dst_d    = dst_q;
    srca_d   = srca_q;
    srcb_d   = srcb_q;
    imm_d    = imm_q;
    snap_d   = snap_q;
    ld_d     = ld_q;
    k_d      = k_q;
    regs_d   = regs_q;
    result_d = result_q;
    flags_d  = flags_q;
    cs_d     = cs_q;
    wr_d     = wr_q;
    maddr_d  = maddr_q;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (Cmd_Valid) begin
          op_d   = op_e'(Cmd_Op);
          wf_d   = Cmd_WF;
          dst_d  = Cmd_Dst;
          srca_d = Cmd_SrcA;
          srcb_d = Cmd_SrcB;
          imm_d  = Cmd_Imm;
          k_d    = '0;
          case (op_e'(Cmd_Op))
            OP_LOAD: begin
              state_d = S_MEM_RD;
              cs_d    = 1'b1;
              wr_d    = 1'b0;
              maddr_d = Cmd_Addr;
            end
            OP_STORE: begin
              // Memory outputs are registered, so the first byte is
              // presented from the acceptance edge onward.
              state_d = S_MEM_WR;
              snap_d  = regs_q[Cmd_Dst];
              cs_d    = 1'b1;
              wr_d    = 1'b1;
              maddr_d = Cmd_Addr;
              wdata_d = regs_q[Cmd_Dst][7:0];
            end
            default: state_d = S_EXEC;
          endcase
        end
      end

      S_EXEC: begin
        regs_d[dst_q] = exec_res;
        result_d      = exec_res;
        if (wf_q && (op_q != OP_LOADI)) flags_d = alu_flags;
        state_d = S_DONE;
      end

      S_MEM_RD: begin
        ld_d = ld_word;
        if (last_k) begin
          regs_d[dst_q] = ld_word;
          result_d      = ld_word;
          cs_d          = 1'b0;
          state_d       = S_DONE;
        end else begin
          k_d     = k_q + KW'(1);
          maddr_d = maddr_q + ADDR_W'(1);
        end
      end

      S_MEM_WR: begin
        if (last_k) begin
          result_d = snap_q;
          cs_d     = 1'b0;
          wr_d     = 1'b0;
          state_d  = S_DONE;
        end else begin
          k_d     = k_q + KW'(1);
          maddr_d = maddr_q + ADDR_W'(1);
          for (int unsigned b = 0; b < BYTES; b++) begin
            if (k_q + KW'(1) == KW'(b)) wdata_d = snap_q[8*b +: 8];
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      wf_q     <= 1'b0;
      dst_q    <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      imm_q    <= '0;
      snap_q   <= '0;
      ld_q     <= '0;
      k_q      <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      result_q <= '0;
      flags_q  <= '0;
      cs_q     <= 1'b0;
      wr_q     <= 1'b0;
      maddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wf_q     <= wf_d;
      dst_q    <= dst_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      imm_q    <= imm_d;
      snap_q   <= snap_d;
      ld_q     <= ld_d;
      k_q      <= k_d;
      regs_q   <= regs_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      cs_q     <= cs_d;
      wr_q     <= wr_d;
      maddr_q  <= maddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign Cmd_Ready   = (state_q == S_IDLE);
  assign Done        = (state_q == S_DONE);
  assign Result      = result_q;
  assign FlagsOut    = flags_q;
  assign Mem_CS      = cs_q;
  assign Mem_WR      = wr_q;
  assign Mem_Address = maddr_q;
  assign Mem_WData   = wdata_q;
  assign Dbg_Data    = regs_q[Dbg_Sel];

endmodule

// File: tb/tb_alu_datapath_seq.sv
// Self-checking bench for alu_datapath_seq (default parameters: 16-bit data,
// 4 registers, 16-bit addresses) against an arithmetic reference model.
module tb_alu_datapath_seq;

  logic        Clock;
  logic        Reset;
  logic        Cmd_Valid;
  logic        Cmd_Ready;
  logic [2:0]  Cmd_Op;
  logic        Cmd_WF;
  logic [1:0]  Cmd_Dst;
  logic [1:0]  Cmd_SrcA;
  logic [1:0]  Cmd_SrcB;
  logic [15:0] Cmd_Imm;
  logic [15:0] Cmd_Addr;
  logic        Done;
  logic [15:0] Result;
  logic [3:0]  FlagsOut;
  logic        Mem_CS;
  logic        Mem_WR;
  logic [15:0] Mem_Address;
  logic [7:0]  Mem_WData;
  logic [7:0]  Mem_RData;
  logic [1:0]  Dbg_Sel;
  logic [15:0] Dbg_Data;

  alu_datapath_seq #(.DATA_W(16), .NUM_REGS(4), .ADDR_W(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_Op(Cmd_Op), .Cmd_WF(Cmd_WF), .Cmd_Dst(Cmd_Dst),
    .Cmd_SrcA(Cmd_SrcA), .Cmd_SrcB(Cmd_SrcB),
    .Cmd_Imm(Cmd_Imm), .Cmd_Addr(Cmd_Addr),
    .Done(Done), .Result(Result), .FlagsOut(FlagsOut),
    .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .Mem_Address(Mem_Address),
    .Mem_WData(Mem_WData), .Mem_RData(Mem_RData),
    .Dbg_Sel(Dbg_Sel), .Dbg_Data(Dbg_Data)
  );

  // Byte-wide memory seen by the DUT
  logic [7:0] mem [65536];
  assign Mem_RData = mem[Mem_Address];
  always @(posedge Clock) if (Mem_CS && Mem_WR) mem[Mem_Address] <= Mem_WData;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Reference model state
  logic [7:0]  ref_mem [65536];
  logic [15:0] m_regs [4];
  logic [15:0] m_result;
  logic [3:0]  m_flags;

  int n_cmp;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sgn16(input logic [15:0] v);
    return v[15] ? int'(v) - 65536 : int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
    m_result = 16'h0;
    m_flags  = 4'h0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      Dbg_Sel = 2'(i);
      #1;
      check_eq(tag, Dbg_Data, m_regs[i]);
    end
  endtask

  // Issue one command, compute its expected effect, and check the whole
  // transaction cycle by cycle up to and including the Done cycle.
  task automatic run_cmd(input logic [2:0] op, input logic wf, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb,
                         input logic [15:0] imm, input logic [15:0] addr);
    logic [15:0] a, b, r, snap, a1;
    logic [3:0]  f;
    logic        z, c, n, o;
    int          full, s, lat, w;

    @(negedge Clock);
    Cmd_Op = op; Cmd_WF = wf; Cmd_Dst = dst; Cmd_SrcA = sa; Cmd_SrcB = sb;
    Cmd_Imm = imm; Cmd_Addr = addr; Cmd_Valid = 1'b1;
    w = 0;
    while (!Cmd_Ready && w < 20) begin
      @(negedge Clock);
      w++;
    end
    check_eq("ready_idle", Cmd_Ready, 1);

    a    = m_regs[sa];
    b    = m_regs[sb];
    snap = m_regs[dst];
    a1   = addr + 16'd1;
    r    = m_result;
    f    = m_flags;
    c    = 1'b0;
    o    = 1'b0;
    case (op)
      3'd0: begin
        full = int'(a) + int'(b); r = full[15:0]; c = (full > 65535);
        s = sgn16(a) + sgn16(b);  o = (s > 32767) || (s < -32768);
      end
      3'd1: begin
        full = int'(a) - int'(b); r = full[15:0]; c = (a < b);
        s = sgn16(a) - sgn16(b);  o = (s > 32767) || (s < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = imm;
      3'd6: r = {ref_mem[a1], ref_mem[addr]};
      default: begin
        r = snap;
        ref_mem[addr] = snap[7:0];
        ref_mem[a1]   = snap[15:8];
      end
    endcase
    z = (r == 16'h0);
    n = r[15];
    if (op <= 3'd4 && wf) f = {z, c, n, o};
    if (op != 3'd7) m_regs[dst] = r;
    m_result = r;
    m_flags  = f;
    lat = (op >= 3'd6) ? 3 : 2;

    @(posedge Clock);
    #1;
    // Keep Valid high with garbage fields while busy: must be ignored.
    Cmd_Op = 3'($urandom); Cmd_WF = 1'($urandom); Cmd_Dst = 2'($urandom);
    Cmd_SrcA = 2'($urandom); Cmd_SrcB = 2'($urandom);
    Cmd_Imm = 16'($urandom); Cmd_Addr = 16'($urandom);

    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge Clock);
      check_eq("done_timing", Done, (cyc == lat));
      check_eq("ready_busy", Cmd_Ready, 0);
      if (cyc < lat && op >= 3'd6) begin
        check_eq("mem_cs", Mem_CS, 1);
        check_eq("mem_wr", Mem_WR, (op == 3'd7));
        check_eq("mem_addr", Mem_Address, 16'(addr + 16'(cyc - 1)));
        if (op == 3'd7) check_eq("mem_wdata", Mem_WData, (cyc == 1) ? snap[7:0] : snap[15:8]);
      end else begin
        check_eq("mem_cs_idle", Mem_CS, 0);
      end
    end
    Cmd_Valid = 1'b0;
    check_eq("result", Result, m_result);
    check_eq("flags", FlagsOut, m_flags);
    if (op == 3'd7) begin
      check_eq("mem_lo", mem[addr], ref_mem[addr]);
      check_eq("mem_hi", mem[a1], ref_mem[a1]);
    end
    check_regs("dbg_reg");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset = 1'b0;
    Cmd_Valid = 1'b0; Cmd_Op = '0; Cmd_WF = 1'b0; Cmd_Dst = '0;
    Cmd_SrcA = '0; Cmd_SrcB = '0; Cmd_Imm = '0; Cmd_Addr = '0; Dbg_Sel = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    model_reset();

    // Reset state
    repeat (2) @(negedge Clock);
    check_eq("rst_ready", Cmd_Ready, 1);
    check_eq("rst_done", Done, 0);
    check_eq("rst_cs", Mem_CS, 0);
    check_eq("rst_wr", Mem_WR, 0);
    check_eq("rst_addr", Mem_Address, 0);
    check_eq("rst_wdata", Mem_WData, 0);
    check_eq("rst_result", Result, 0);
    check_eq("rst_flags", FlagsOut, 0);
    check_regs("rst_reg");
    @(negedge Clock);
    Reset = 1'b1;

    // ADD signed overflow
    run_cmd(3'd5, 1'b0, 2'd0, 2'd0, 2'd0, 16'h7FFF, 16'h0);
    run_cmd(3'd5, 1'b0, 2'd1, 2'd0, 2'd0, 16'h0001, 16'h0);
    run_cmd(3'd0, 1'b1, 2'd2, 2'd0, 2'd1, 16'h0, 16'h0);
    check_eq("add_flags_0011", FlagsOut, 4'b0011);
    check_eq("add_res_8000", Result, 16'h8000);

    // SUB with all three selects equal, then a borrow
    run_cmd(3'd5, 1'b0, 2'd3, 2'd0, 2'd0, 16'h0005, 16'h0);
    run_cmd(3'd1, 1'b1, 2'd3, 2'd3, 2'd3, 16'h0, 16'h0);
    check_eq("sub_self_flags", FlagsOut, 4'b1000);
    run_cmd(3'd5, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0001, 16'h0);
    run_cmd(3'd5, 1'b0, 2'd1, 2'd0, 2'd0, 16'h0002, 16'h0);
    run_cmd(3'd1, 1'b1, 2'd2, 2'd0, 2'd1, 16'h0, 16'h0);
    check_eq("sub_borrow_res", Result, 16'hFFFF);

    // LOAD across the address wrap
    mem[16'hFFFF] = 8'h34; ref_mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12; ref_mem[16'h0000] = 8'h12;
    run_cmd(3'd6, 1'b1, 2'd1, 2'd0, 2'd0, 16'h0, 16'hFFFF);
    check_eq("load_wrap", Result, 16'h1234);

    // STORE
    run_cmd(3'd5, 1'b0, 2'd2, 2'd0, 2'd0, 16'hABCD, 16'h0);
    run_cmd(3'd7, 1'b1, 2'd2, 2'd0, 2'd0, 16'h0, 16'h0100);
    check_eq("store_lo", mem[16'h0100], 8'hCD);
    check_eq("store_hi", mem[16'h0101], 8'hAB);

    // AND without flag update
    run_cmd(3'd5, 1'b0, 2'd0, 2'd0, 2'd0, 16'hF0F0, 16'h0);
    run_cmd(3'd2, 1'b0, 2'd3, 2'd0, 2'd2, 16'h0, 16'h0);
    check_eq("and_res", Result, 16'hA0C0);

    // Reset during the second byte of a STORE
    mem[16'h0201] = 8'h5A; ref_mem[16'h0201] = 8'h5A;
    @(negedge Clock);
    Cmd_Op = 3'd7; Cmd_Dst = 2'd2; Cmd_Addr = 16'h0200; Cmd_Valid = 1'b1;
    @(posedge Clock);
    #1 Cmd_Valid = 1'b0;
    @(negedge Clock);
    check_eq("rstwr_b0_addr", Mem_Address, 16'h0200);
    @(negedge Clock);
    check_eq("rstwr_b1_addr", Mem_Address, 16'h0201);
    Reset = 1'b0;
    #1;
    check_eq("rstwr_cs", Mem_CS, 0);
    check_eq("rstwr_wr", Mem_WR, 0);
    check_eq("rstwr_addr", Mem_Address, 0);
    check_eq("rstwr_result", Result, 0);
    check_eq("rstwr_flags", FlagsOut, 0);
    model_reset();
    ref_mem[16'h0200] = 8'hCD;
    @(negedge Clock);
    check_eq("rstwr_b0_written", mem[16'h0200], 8'hCD);
    check_eq("rstwr_b1_kept", mem[16'h0201], 8'h5A);
    check_regs("rstwr_reg");
    Reset = 1'b1;
    @(negedge Clock);
    check_eq("rstwr_ready", Cmd_Ready, 1);

    // Randomized commands
    for (int t = 0; t < 120; t++) begin
      logic [15:0] ad;
      ad = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      run_cmd(3'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
              16'($urandom), ad);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_datapath_seq.md
Name: alu_datapath_seq

Overview:
Parametrised successor to the current ALU system datapath. It combines a general register file, an ALU with a flag register and a byte-serial memory sequencer. The whole block is driven by a valid/ready command interface, which replaces the raw per-field select lines.
Multi-byte loads and stores are sequenced internally, so the controller no longer steps the byte-half mux by hand. The block sits between the control unit and the byte-wide Memory.

Parameters:
DATA_W, 16, register/ALU width; must be a multiple of 8; BYTES = DATA_W/8
NUM_REGS, 4, number of general registers; power of 2, >= 2; RSEL_W = clog2(NUM_REGS)
ADDR_W, 16, memory address width

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
Cmd_Valid  in  1  command present
Cmd_Ready  out  1  block can accept a command
Cmd_Op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LOADI, 110 LOAD, 111 STORE
Cmd_WF  in  1  update flags (ALU ops only)
Cmd_Dst  in  RSEL_W  destination register (source register for STORE)
Cmd_SrcA  in  RSEL_W  operand A register
Cmd_SrcB  in  RSEL_W  operand B register
Cmd_Imm  in  DATA_W  immediate for LOADI
Cmd_Addr  in  ADDR_W  base byte address for LOAD/STORE
Done  out  1  one-cycle pulse when a command completes
Result  out  DATA_W  value written or stored by the last command
FlagsOut  out  4  {Z,C,N,O}
Mem_CS  out  1  memory select, active-high
Mem_WR  out  1  1 = write, 0 = read
Mem_Address  out  ADDR_W  byte address
Mem_WData  out  8  write byte
Mem_RData  in  8  read byte; combinational from Mem_Address
Dbg_Sel  in  RSEL_W  register observation select
Dbg_Data  out  DATA_W  combinational read of register Dbg_Sel

Behaviour:
- Reset (async, Reset=0), regardless of current state including mid-transfer:
  - all registers, Result, FlagsOut = 0; Done = 0; Mem_CS = Mem_WR = 0; Mem_Address = 0; Mem_WData = 0.
  - state = IDLE.
  - no memory write is issued after reset asserts.
- States: IDLE, EXEC, MEM_RD, MEM_WR, DONE.
- Cmd_Ready = 1 only in IDLE. A command is accepted on the rising edge where Cmd_Valid & Cmd_Ready.
  - All Cmd_* fields are latched at acceptance; later input changes are ignored.
  - Cmd_Valid while busy has no effect.
- IDLE -> EXEC for ALU ops and LOADI; IDLE -> MEM_RD for LOAD; IDLE -> MEM_WR for STORE. Byte counter k = 0 on acceptance.
- EXEC (1 cycle):
  - operands are read from the register file at latched SrcA/SrcB.
  - on the exiting edge: Dst and Result <= ALU result (LOADI: Imm); flags updated if WF=1 and op is not LOADI.
  - EXEC -> DONE.
- ALU arithmetic is width DATA_W, unsigned modulo 2^DATA_W.
  - ADD: C = carry-out.
  - SUB: A-B, C = borrow (1 when A<B unsigned).
  - O = signed overflow; N = MSB; Z = (result == 0).
  - Logic ops: C = O = 0.
- SrcA == SrcB == Dst is legal. Operands are read before the write edge.
- MEM_RD (BYTES cycles):
  - Mem_CS = 1, Mem_WR = 0, Mem_Address = (Addr + k) mod 2^ADDR_W.
  - Mem_RData is captured into byte lane k (little-endian: k=0 to bits [7:0]) on each edge.
  - After k = BYTES-1: Dst and Result <= assembled word; flags unchanged; -> DONE.
- MEM_WR (BYTES cycles):
  - Mem_CS = 1, Mem_WR = 1, Mem_Address = Addr + k (wrapping), Mem_WData = snapshot of Dst taken at acceptance, lane k.
  - Result <= snapshot; -> DONE after the last byte.
- Memory outputs are registered and must be valid for the entire cycle they are asserted. Mem_CS = 0 in IDLE, EXEC and DONE.
- DONE (1 cycle): Done = 1; -> IDLE. Next acceptance is possible on the edge ending DONE+1, i.e. the first IDLE cycle.
- Latency from the acceptance edge to the Done cycle: 2 cycles for ALU/LOADI, BYTES+1 cycles for LOAD/STORE.
- Address wrap: ADDR_W-bit wraparound within a single transfer (0xFFFF -> 0x0000).

Test Plan:
- R0 = 0x7FFF, R1 = 0x0001, ADD Dst=R2, WF=1 -> R2 = 0x8000, FlagsOut {Z,C,N,O} = 0011, Done 2 cycles after accept.
- R3 = 0x0005, SUB A=R3, B=R3, Dst=R3, WF=1 -> R3 = 0, Z=1, C=0, N=0, O=0. Then SUB 0x0001-0x0002 -> 0xFFFF, C=1, N=1.
- Memory[0xFFFF] = 0x34, [0x0000] = 0x12; LOAD Dst=R1, Addr=0xFFFF -> reads at 0xFFFF then 0x0000, R1 = 0x1234, flags unchanged, Done at accept+3.
- R2 = 0xABCD; STORE Dst=R2, Addr=0x0100 -> Mem_WR cycles write 0xCD@0x0100 then 0xAB@0x0101; Result = 0xABCD; Cmd_Ready = 0 throughout. Cmd_Valid held high is re-accepted only in IDLE.
- Reset=0 during the second MEM_WR byte -> Mem_CS drops immediately, no further writes, all registers = 0, Cmd_Ready = 1 after release.
- Cmd_Op change while busy plus AND with WF=0 -> result correct, FlagsOut unchanged, latched fields used; Dbg_Data tracks the written register on the cycle after the write edge.
